mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multi-cycle control FSM for the RV32 core: sequences the shared PC/ALU/register file/unified memory datapath through fetch, decode, execute, memory and writeback.
//  Emits per-cycle mux selects and write strobes, decodes ALUcontrol, waits on a memory ready handshake and counts retired instructions.
//  Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
// PARAMETERS
//  INSTRET_W   32   width of retired-instruction counter
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous reset, active-low
//  op           in   7          instr[6:0], valid from DECODE onward (IR-held)
//  funct3       in   3          instr[14:12]
//  funct7b5     in   1          instr[30]
//  zero         in   1          ALU Ze flag
//  mem_ready    in   1          memory completes access this cycle
//  PCWrite      out  1          PC register load strobe
//  AdrSrc       out  1          memory address: 0=PC, 1=Result
//  MemWrite     out  1          memory write strobe
//  IRWrite      out  1          instruction/OldPC register load
//  ResultSrc    out  2          00=ALUOut, 01=read data, 10=ALU result
//  ALUSrcA      out  2          00=PC, 01=OldPC, 10=RD1
//  ALUSrcB      out  2          00=RD2, 01=ImmExt, 10=const 4
//  ImmSrc       out  2          00=I, 01=S, 10=B, 11=J (from op, combinational)
//  ALUcontrol   out  3          000 add, 001 sub, 010 and, 011 or, 101 slt
//  RegWrite     out  1          register file WE3
//  illegal      out  1          illegal-opcode flag (see CONFIGURATION)
//  state_dbg    out  4          current state encoding
//  instret      out  INSTRET_W  retired instruction count
// BEHAVIOUR
//  - States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
//  - rst low: state=FETCH, instret=0, illegal=0; PCWrite/IRWrite/RegWrite/MemWrite forced 0; selects show FETCH values.
//  - Outputs are combinational from state (plus mem_ready/zero where noted); state updates on clk rising edge.
//  - FETCH: AdrSrc0, SrcA00, SrcB10, add, ResultSrc10.
//    - mem_ready=1: IRWrite=PCWrite=1, go DECODE.
//    - mem_ready=0: stay, strobes 0.
//  - DECODE: SrcA01, SrcB01, add (branch target into ALUOut). Next state by op:
//    - 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
//    - other op -> FETCH, or TRAP when MC_ILLEGAL_TRAP_EN is defined.
//  - MEMADR: SrcA10, SrcB01, add; op 0000011 -> MEMREAD, else MEMWRITE.
//  - MEMREAD: AdrSrc1, ResultSrc00; hold until mem_ready, then MEMWB.
//  - MEMWB: ResultSrc01, RegWrite=1 -> FETCH.
//  - MEMWRITE: AdrSrc1, ResultSrc00, MemWrite=1 held every cycle until mem_ready, then FETCH.
//  - EXECR: SrcA10, SrcB00, funct decode -> ALUWB.
//  - EXECI: SrcA10, SrcB01, funct decode -> ALUWB.
//  - ALUWB: ResultSrc00, RegWrite=1 -> FETCH.
//  - BEQ: SrcA10, SrcB00, sub, ResultSrc00, PCWrite=zero -> FETCH.
//  - JAL: SrcA01, SrcB10, add, ResultSrc00, PCWrite=1 -> ALUWB (rd=PC+4).
//  - Funct decode, by funct3:
//    - 000: sub if op[5]&funct7b5, else add.
//    - 010: slt; 110: or; 111: and; others: add.
//  - Strobes/selects not listed for a state are 0/00; in those states ALUcontrol=add.
//  - instret increments by 1 (wraps at 2^INSTRET_W) on every transition into FETCH from a non-FETCH state.
//  - A mem_ready stall does not increment instret.
//  - Reset asserted mid-instruction aborts it: no strobe after rst falls, no count.
// CONFIGURATION
//  MC_ILLEGAL_TRAP_EN defined:
//    - undecoded op in DECODE -> TRAP.
//    - TRAP: illegal=1, all strobes 0, state held until rst; instret frozen.
//  Not defined:
//    - undecoded op retires as NOP (DECODE -> FETCH, instret+1); illegal tied 0; TRAP unreachable.
// TESTING
//  - rst low 3 cycles, mem_ready=1 -> state_dbg=0, instret=0, all strobes 0; after release PCWrite=IRWrite=1 in first cycle.
//  - lw, mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; RegWrite=1 only in MEMWB; instret=1.
//  - sw, mem_ready delayed 1 cycle -> MemWrite=1 for 2 cycles, AdrSrc=1, RegWrite never set.
//  - R-type funct3=000 funct7b5=1 -> ALUcontrol=001 in EXECR; funct7b5=0 -> 000; I-type funct3=000 funct7b5=1 -> 000.
//  - beq zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; jal -> PCWrite in JAL, RegWrite in ALUWB.
//  - op=7'h7F: with macro -> state 11, illegal=1, no strobes for 20 cycles; without -> FETCH, instret+1.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the RV32 core: drives datapath selects and strobes per state.
// Optional MC_ILLEGAL_TRAP_EN: undecoded opcodes park the FSM in a TRAP state with illegal=1.
module mc_controller #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUcontrol,
  output logic                 RegWrite,
  output logic                 illegal,
  output logic [3:0]           state_dbg,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q;
  logic [2:0]           alu_funct;
  logic                 pc_write, mem_write, ir_write, reg_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      // Retire on every return to FETCH; fetch stalls stay in FETCH and do not count.
      if (state_q != StFetch && state_d == StFetch) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  // Subtract only for R-type (op[5]) with funct7b5; I-type funct7 bits are immediate.
  always_comb begin
    alu_funct = AluAdd;
    case (funct3)
      3'b000:  alu_funct = (op[5] & funct7b5) ? AluSub : AluAdd;
      3'b010:  alu_funct = AluSlt;
      3'b110:  alu_funct = AluOr;
      3'b111:  alu_funct = AluAnd;
      default: alu_funct = AluAdd;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpStore: ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUcontrol = AluAdd;

    unique case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
`ifdef MC_ILLEGAL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUcontrol = alu_funct;
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUcontrol = alu_funct;
        state_d    = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBeq: begin
        ALUSrcA    = 2'b10;
        ALUcontrol = AluSub;
        pc_write   = zero;
        state_d    = StFetch;
      end
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = StAluWb;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      StTrap: begin
        state_d = StTrap;
      end
`endif
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // FETCH strobes depend on mem_ready, so they must be masked while reset is held.
  assign PCWrite  = pc_write & rst;
  assign IRWrite  = ir_write & rst;
  assign RegWrite = reg_write & rst;
  assign MemWrite = mem_write & rst;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = (state_q == StTrap);
`else
  assign illegal = 1'b0;
`endif

  assign state_dbg = state_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; follows MC_ILLEGAL_TRAP_EN for the trap test.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUcontrol;
  logic [3:0]  state_dbg;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_instret = '0;

  always #5 clk = ~clk;

  mc_controller #(.INSTRET_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUcontrol (ALUcontrol),
    .RegWrite   (RegWrite),
    .illegal    (illegal),
    .state_dbg  (state_dbg),
    .instret    (instret)
  );

  // Set mem_ready for the current cycle and move to the sampling point.
  task automatic drive(input logic r);
    mem_ready = r;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    checks++; if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUcontrol} !== {1'b0, 2'b00, 2'b10, 2'b10, 3'b000}) begin
      errors++; $display("FAIL reset_selects: got %b expected 0001010000",
                         {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUcontrol});
    end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    rst = 1'b1;
    #1;
    checks++; if ({PCWrite, IRWrite} !== 2'b11) begin
      errors++; $display("FAIL release_fetch: got %b expected 11", {PCWrite, IRWrite});
    end
    mem_ready = 1'b0;
    advance();
  endtask

  task automatic test_lw();
    logic [3:0] es [8];
    logic       rd [8];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      drive(rd[i]);
      checks++; if (state_dbg !== es[i]) begin
        errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_dbg, es[i]);
      end
      checks++; if (RegWrite !== (es[i] == 4'd4)) begin
        errors++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", i, RegWrite, es[i] == 4'd4);
      end
      if (i == 1) begin
        checks++; if ({ALUSrcA, ALUSrcB, ImmSrc} !== 6'b010100) begin
          errors++; $display("FAIL lw_decode_sel: got %b expected 010100", {ALUSrcA, ALUSrcB, ImmSrc});
        end
      end
      if (i == 3) begin
        checks++; if ({AdrSrc, ResultSrc} !== 3'b100) begin
          errors++; $display("FAIL lw_memread_sel: got %b expected 100", {AdrSrc, ResultSrc});
        end
      end
      if (i == 6) begin
        checks++; if (ResultSrc !== 2'b01) begin
          errors++; $display("FAIL lw_memwb_result: got %b expected 01", ResultSrc);
        end
      end
      if (i == 6) exp_instret++;
      advance();
    end
    @(negedge clk);
    checks++; if (instret !== exp_instret) begin
      errors++; $display("FAIL lw_instret: got %0d expected %0d", instret, exp_instret);
    end
    advance();
  endtask

  task automatic test_sw();
    logic [3:0] es [6];
    logic       rd [6];
    int         mw_cycles;
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 7'b0100011; funct3 = 3'b010;
    mw_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      drive(rd[i]);
      if (MemWrite === 1'b1) mw_cycles++;
      checks++; if (state_dbg !== es[i]) begin
        errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state_dbg, es[i]);
      end
      checks++; if (RegWrite !== 1'b0) begin
        errors++; $display("FAIL sw_regwrite[%0d]: got %b expected 0", i, RegWrite);
      end
      if (es[i] == 4'd5) begin
        checks++; if (AdrSrc !== 1'b1) begin
          errors++; $display("FAIL sw_adrsrc[%0d]: got %b expected 1", i, AdrSrc);
        end
      end
      if (i == 1) begin
        checks++; if (ImmSrc !== 2'b01) begin errors++; $display("FAIL sw_immsrc: got %b expected 01", ImmSrc); end
      end
      if (i == 4) exp_instret++;
      advance();
    end
    checks++; if (mw_cycles != 2) begin
      errors++; $display("FAIL sw_memwrite_cycles: got %0d expected 2", mw_cycles);
    end
    @(negedge clk);
    checks++; if (instret !== exp_instret) begin
      errors++; $display("FAIL sw_instret: got %0d expected %0d", instret, exp_instret);
    end
    advance();
  endtask

  task automatic test_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [2:0] exp_alu, input string name);
    logic [3:0] exec_st;
    logic [1:0] exec_srcb;
    exec_st   = (o == 7'b0110011) ? 4'd6 : 4'd7;
    exec_srcb = (o == 7'b0110011) ? 2'b00 : 2'b01;
    op = o; funct3 = f3; funct7b5 = f7;
    drive(1'b1); advance();
    drive(1'b0); advance();
    drive(1'b0);
    checks++; if (state_dbg !== exec_st) begin
      errors++; $display("FAIL %s_exec_state: got %0d expected %0d", name, state_dbg, exec_st);
    end
    checks++; if (ALUcontrol !== exp_alu) begin
      errors++; $display("FAIL %s_alucontrol: got %b expected %b", name, ALUcontrol, exp_alu);
    end
    checks++; if ({ALUSrcA, ALUSrcB} !== {2'b10, exec_srcb}) begin
      errors++; $display("FAIL %s_exec_srcs: got %b expected %b", name, {ALUSrcA, ALUSrcB}, {2'b10, exec_srcb});
    end
    advance();
    drive(1'b0);
    checks++; if ({state_dbg, RegWrite, ALUcontrol} !== {4'd8, 1'b1, 3'b000}) begin
      errors++; $display("FAIL %s_aluwb: got %b expected 10001000", name, {state_dbg, RegWrite, ALUcontrol});
    end
    exp_instret++;
    advance();
    drive(1'b0);
    checks++; if (instret !== exp_instret) begin
      errors++; $display("FAIL %s_instret: got %0d expected %0d", name, instret, exp_instret);
    end
    advance();
  endtask

  task automatic test_alu_decode();
    test_alu(7'b0110011, 3'b000, 1'b1, 3'b001, "r_sub");
    test_alu(7'b0110011, 3'b000, 1'b0, 3'b000, "r_add");
    test_alu(7'b0110011, 3'b010, 1'b0, 3'b101, "r_slt");
    test_alu(7'b0110011, 3'b110, 1'b0, 3'b011, "r_or");
    test_alu(7'b0110011, 3'b111, 1'b1, 3'b010, "r_and");
    test_alu(7'b0110011, 3'b100, 1'b0, 3'b000, "r_other");
    test_alu(7'b0010011, 3'b000, 1'b1, 3'b000, "i_add");
    test_alu(7'b0010011, 3'b110, 1'b0, 3'b011, "i_or");
  endtask

  task automatic test_beq();
    logic z [2];
    z = '{1'b1, 1'b0};
    op = 7'b1100011; funct3 = 3'b000;
    for (int i = 0; i < 2; i++) begin
      zero = z[i];
      drive(1'b1); advance();
      drive(1'b0);
      checks++; if (ImmSrc !== 2'b10) begin errors++; $display("FAIL beq_immsrc: got %b expected 10", ImmSrc); end
      advance();
      drive(1'b0);
      checks++; if (state_dbg !== 4'd9) begin errors++; $display("FAIL beq_state: got %0d expected 9", state_dbg); end
      checks++; if ({PCWrite, ALUcontrol} !== {z[i], 3'b001}) begin
        errors++; $display("FAIL beq_pcwrite_z%0d: got %b expected %b", z[i], {PCWrite, ALUcontrol}, {z[i], 3'b001});
      end
      exp_instret++;
      advance();
      drive(1'b0);
      checks++; if ({state_dbg, instret} !== {4'd0, exp_instret}) begin
        errors++; $display("FAIL beq_retire: got %0d/%0d expected 0/%0d", state_dbg, instret, exp_instret);
      end
      advance();
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    op = 7'b1101111;
    drive(1'b1); advance();
    drive(1'b0);
    checks++; if (ImmSrc !== 2'b11) begin errors++; $display("FAIL jal_immsrc: got %b expected 11", ImmSrc); end
    advance();
    drive(1'b0);
    checks++; if ({state_dbg, PCWrite, RegWrite, ALUSrcA, ALUSrcB} !== {4'd10, 1'b1, 1'b0, 2'b01, 2'b10}) begin
      errors++; $display("FAIL jal_state: got %b expected 1010100110", {state_dbg, PCWrite, RegWrite, ALUSrcA, ALUSrcB});
    end
    advance();
    drive(1'b0);
    checks++; if ({state_dbg, PCWrite, RegWrite} !== {4'd8, 1'b0, 1'b1}) begin
      errors++; $display("FAIL jal_aluwb: got %b expected 100001", {state_dbg, PCWrite, RegWrite});
    end
    exp_instret++;
    advance();
    drive(1'b0);
    checks++; if (instret !== exp_instret) begin
      errors++; $display("FAIL jal_instret: got %0d expected %0d", instret, exp_instret);
    end
    advance();
  endtask

  task automatic test_reset_abort();
    op = 7'b0100011;
    drive(1'b1); advance();
    drive(1'b0); advance();
    drive(1'b0); advance();
    drive(1'b0);
    checks++; if ({state_dbg, MemWrite} !== {4'd5, 1'b1}) begin
      errors++; $display("FAIL abort_pre: got %b expected 01011", {state_dbg, MemWrite});
    end
    rst = 1'b0;
    #1;
    checks++; if ({state_dbg, MemWrite, PCWrite, IRWrite, RegWrite} !== {4'd0, 4'b0000}) begin
      errors++; $display("FAIL abort_strobes: got %b expected 00000000",
                         {state_dbg, MemWrite, PCWrite, IRWrite, RegWrite});
    end
    checks++; if (instret !== 32'd0) begin
      errors++; $display("FAIL abort_instret: got %0d expected 0", instret);
    end
    exp_instret = '0;
    advance();
    rst = 1'b1;
    advance();
  endtask

  task automatic test_illegal();
    op = 7'h7F;
    drive(1'b1); advance();
    drive(1'b0); advance();
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      drive(1'b1);
      checks++; if ({state_dbg, illegal} !== {4'd11, 1'b1}) begin
        errors++; $display("FAIL trap_state[%0d]: got %b expected 10111", i, {state_dbg, illegal});
      end
      checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
        errors++; $display("FAIL trap_strobes[%0d]: got %b expected 0000", i, {PCWrite, IRWrite, RegWrite, MemWrite});
      end
      checks++; if (instret !== exp_instret) begin
        errors++; $display("FAIL trap_instret[%0d]: got %0d expected %0d", i, instret, exp_instret);
      end
      advance();
    end
`else
    drive(1'b0);
    exp_instret++;
    checks++; if ({state_dbg, illegal} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL nop_state: got %b expected 00000", {state_dbg, illegal});
    end
    checks++; if (instret !== exp_instret) begin
      errors++; $display("FAIL nop_instret: got %0d expected %0d", instret, exp_instret);
    end
    advance();
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu_decode();
    test_beq();
    test_jal();
    test_reset_abort();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
